// File: rtl/pong_pt2.sv
// Parametrised pong core: VGA raster timing with pixel divider, wall/paddle/ball
// renderer on an RGB_W-bit bus, and a saturating missed-ball counter.
module pong_pt2 #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned TICK_DIV  = 2,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned RGB_W     = 3,
    parameter int unsigned WALL_XL   = 32,
    parameter int unsigned WALL_XR   = 35,
    parameter int unsigned PAD_XL    = 600,
    parameter int unsigned PAD_XR    = 603,
    parameter int unsigned PAD_H     = 72,
    parameter int unsigned PAD_V     = 4,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned BALL_V    = 2,
    parameter logic [RGB_W-1:0] WALL_RGB = RGB_W'(1),
    parameter logic [RGB_W-1:0] PAD_RGB  = RGB_W'(2),
    parameter logic [RGB_W-1:0] BALL_RGB = RGB_W'(4)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic up,
    input  logic down,
    output logic p_tick,
    output logic hsync,
    output logic vsync,
    output logic video_on,
    output logic [RGB_W-1:0] rgb,
    output logic [$clog2(H_DISPLAY+H_FP+H_SYNC+H_BP)-1:0] pixel_x,
    output logic [$clog2(V_DISPLAY+V_FP+V_SYNC+V_BP)-1:0] pixel_y,
    output logic frame_tick,
    output logic [3:0] miss_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HS_BEG  = H_DISPLAY + H_FP;
    localparam int unsigned HS_END  = H_DISPLAY + H_FP + H_SYNC - 1;
    localparam int unsigned VS_BEG  = V_DISPLAY + V_FP;
    localparam int unsigned VS_END  = V_DISPLAY + V_FP + V_SYNC - 1;
    localparam int unsigned BX0     = (H_DISPLAY - BALL_SIZE) / 2;
    localparam int unsigned BY0     = (V_DISPLAY - BALL_SIZE) / 2;
    localparam int unsigned PAD_Y0  = (V_DISPLAY - PAD_H) / 2;
    localparam int unsigned PAD_MAX = V_DISPLAY - PAD_H;
    localparam int unsigned MISS_X  = H_DISPLAY - BALL_SIZE - BALL_V;
    localparam int unsigned BOT_Y   = V_DISPLAY - BALL_SIZE - BALL_V;
    localparam int unsigned WALL_X  = WALL_XR + 1 + BALL_V;

    logic [TW-1:0]    tick_q, tick_d;
    logic [XW-1:0]    h_q, h_d;
    logic [YW-1:0]    v_q, v_d;
    logic             hs_q, hs_d, vs_q, vs_d, von_q, von_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [YW-1:0]    pad_q, pad_d;
    logic [XW-1:0]    bx_q, bx_d;
    logic [YW-1:0]    by_q, by_d;
    logic             dx_q, dx_d, dy_q, dy_d;
    logic [3:0]       miss_q, miss_d;

    logic [31:0] h32, v32, pad32, bx32, by32;
    logic        tick_last, h_last, v_last, p_tick_c, frame_c;
    logic        vis, on_wall, on_pad, on_ball, hit;

    // Next-state: divider, raster counters, output register and per-frame game update
    always_comb begin
        h32       = 32'(h_q);
        v32       = 32'(v_q);
        pad32     = 32'(pad_q);
        bx32      = 32'(bx_q);
        by32      = 32'(by_q);
        tick_last = (32'(tick_q) == TICK_DIV - 1);
        h_last    = (h32 == H_TOTAL - 1);
        v_last    = (v32 == V_TOTAL - 1);
        p_tick_c  = enable && !reset && tick_last;
        frame_c   = p_tick_c && h_last && (v32 == V_DISPLAY - 1);
        vis       = (h32 < H_DISPLAY) && (v32 < V_DISPLAY);
        on_wall   = (h32 >= WALL_XL) && (h32 <= WALL_XR);
        on_pad    = (h32 >= PAD_XL) && (h32 <= PAD_XR) &&
                    (v32 >= pad32) && (v32 <= pad32 + PAD_H - 1);
        on_ball   = (h32 >= bx32) && (h32 <= bx32 + BALL_SIZE - 1) &&
                    (v32 >= by32) && (v32 <= by32 + BALL_SIZE - 1);
        hit       = 1'b0;

        tick_d = tick_q;
        h_d    = h_q;
        v_d    = v_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        von_d  = von_q;
        rgb_d  = rgb_q;
        pad_d  = pad_q;
        bx_d   = bx_q;
        by_d   = by_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        miss_d = miss_q;

        if (enable) begin
            tick_d = tick_last ? '0 : tick_q + TW'(1);
        end

        if (p_tick_c) begin
            h_d = h_last ? '0 : h_q + XW'(1);
            if (h_last) begin
                v_d = v_last ? '0 : v_q + YW'(1);
            end
            hs_d  = ((h32 >= HS_BEG) && (h32 <= HS_END)) ? SYNC_POL : !SYNC_POL;
            vs_d  = ((v32 >= VS_BEG) && (v32 <= VS_END)) ? SYNC_POL : !SYNC_POL;
            von_d = vis;
            if (!vis)        rgb_d = '0;
            else if (on_wall) rgb_d = WALL_RGB;
            else if (on_pad)  rgb_d = PAD_RGB;
            else if (on_ball) rgb_d = BALL_RGB;
            else              rgb_d = '0;
        end

        // Game state moves once per frame; the ball sees the paddle before it moves
        if (frame_c) begin
            if (up && !down) begin
                pad_d = YW'((pad32 > PAD_V) ? pad32 - PAD_V : 32'd0);
            end else if (down && !up) begin
                pad_d = YW'((pad32 + PAD_V > PAD_MAX) ? PAD_MAX : pad32 + PAD_V);
            end

            if (bx32 >= MISS_X) begin
                bx_d   = XW'(BX0);
                by_d   = YW'(BY0);
                dx_d   = 1'b1;
                dy_d   = 1'b1;
                miss_d = (miss_q == 4'd15) ? miss_q : miss_q + 4'd1;
            end else begin
                if (by32 <= BALL_V) dy_d = 1'b1;
                if (by32 >= BOT_Y)  dy_d = 1'b0;
                if (bx32 <= WALL_X) dx_d = 1'b1;
                hit = dx_d &&
                      (bx32 + BALL_SIZE >= PAD_XL) && (bx32 + BALL_SIZE <= PAD_XL + BALL_V) &&
                      (by32 <= pad32 + PAD_H - 1) && (by32 + BALL_SIZE - 1 >= pad32);
                if (hit) dx_d = 1'b0;
                bx_d = XW'(dx_d ? bx32 + BALL_V : bx32 - BALL_V);
                by_d = YW'(dy_d ? by32 + BALL_V : by32 - BALL_V);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= !SYNC_POL;
            vs_q   <= !SYNC_POL;
            von_q  <= 1'b0;
            rgb_q  <= '0;
            pad_q  <= YW'(PAD_Y0);
            bx_q   <= XW'(BX0);
            by_q   <= YW'(BY0);
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            miss_q <= '0;
        end else begin
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            von_q  <= von_d;
            rgb_q  <= rgb_d;
            pad_q  <= pad_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            miss_q <= miss_d;
        end
    end

    assign p_tick     = p_tick_c;
    assign frame_tick = frame_c;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign video_on   = von_q;
    assign rgb        = rgb_q;
    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_pong_pt2.sv
// Randomised bench for pong_pt2 on a tiny raster, compared every clock against
// an arithmetic model (pixel index from enabled-clock count, game rules per frame).
module tb_pong_pt2;

    localparam int HD = 12, HFP = 1, HSY = 1, HBP = 1;
    localparam int VD = 10, VFP = 1, VSY = 1, VBP = 1;
    localparam int TD = 2;
    localparam bit SP = 1'b1;
    localparam int WXL = 1, WXR = 1, PXL = 9, PXR = 9, PH = 3, PV = 1, BS = 1, BV = 1;
    localparam int HT = HD + HFP + HSY + HBP;
    localparam int VT = VD + VFP + VSY + VBP;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int C_WALL = 1, C_PAD = 2, C_BALL = 4;

    logic clk, rst, en, up, down;
    logic p_tick, hsync, vsync, video_on, frame_tick;
    logic [2:0]    rgb;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [3:0]    miss_cnt;

    int total = 0;
    int bad   = 0;

    pong_pt2 #(
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .TICK_DIV(TD), .SYNC_POL(SP), .RGB_W(3),
        .WALL_XL(WXL), .WALL_XR(WXR), .PAD_XL(PXL), .PAD_XR(PXR),
        .PAD_H(PH), .PAD_V(PV), .BALL_SIZE(BS), .BALL_V(BV),
        .WALL_RGB(3'b001), .PAD_RGB(3'b010), .BALL_RGB(3'b100)
    ) dut (
        .clk(clk), .reset(rst), .enable(en), .up(up), .down(down),
        .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .rgb(rgb), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_tick(frame_tick), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state
    int n;
    bit m_hs, m_vs, m_von;
    int m_rgb, pad, bx, by, vx, vy, miss;
    bit chk_on = 1'b0;

    function automatic int pix_rgb(input int h, input int v);
        if (!(h < HD && v < VD))                               return 0;
        if (h >= WXL && h <= WXR)                              return C_WALL;
        if (h >= PXL && h <= PXR && v >= pad && v <= pad+PH-1) return C_PAD;
        if (h >= bx && h <= bx+BS-1 && v >= by && v <= by+BS-1) return C_BALL;
        return 0;
    endfunction

    task automatic game_step();
        if (bx >= HD - BS - BV) begin
            bx = (HD - BS) / 2; by = (VD - BS) / 2; vx = 1; vy = 1;
            if (miss < 15) miss++;
        end else begin
            if (by <= BV) vy = 1;
            if (by >= VD - BS - BV) vy = -1;
            if (bx <= WXR + 1 + BV) vx = 1;
            if (vx > 0 && bx+BS >= PXL && bx+BS <= PXL+BV && by <= pad+PH-1 && by+BS-1 >= pad)
                vx = -1;
            bx += vx * BV;
            by += vy * BV;
        end
        if (up && !down)      pad = (pad > PV) ? pad - PV : 0;
        else if (down && !up) pad = (pad + PV > VD - PH) ? VD - PH : pad + PV;
    endtask

    // Compare DUT with model mid-cycle, then advance the model across the next edge
    always @(negedge clk) begin : mdl
        int tk, pp, h, v;
        bit pt, ft;
        tk = n % TD;
        pp = n / TD;
        h  = pp % HT;
        v  = (pp / HT) % VT;
        pt = en && !rst && (tk == TD - 1);
        ft = pt && (h == HT - 1) && (v == VD - 1);
        if (chk_on) begin
            chk("p_tick", 32'(p_tick), 32'(pt));
            chk("frame_tick", 32'(frame_tick), 32'(ft));
            chk("pixel_x", 32'(pixel_x), 32'(h));
            chk("pixel_y", 32'(pixel_y), 32'(v));
            chk("hsync", 32'(hsync), 32'(m_hs));
            chk("vsync", 32'(vsync), 32'(m_vs));
            chk("video_on", 32'(video_on), 32'(m_von));
            chk("rgb", 32'(rgb), 32'(m_rgb));
            chk("miss_cnt", 32'(miss_cnt), 32'(miss));
        end
        if (rst) begin
            n = 0; m_hs = !SP; m_vs = !SP; m_von = 0; m_rgb = 0;
            pad = (VD - PH) / 2; bx = (HD - BS) / 2; by = (VD - BS) / 2;
            vx = 1; vy = 1; miss = 0;
            chk_on = 1'b1;
        end else if (en) begin
            if (pt) begin
                m_hs  = (h >= HD+HFP && h <= HD+HFP+HSY-1) ? SP : !SP;
                m_vs  = (v >= VD+VFP && v <= VD+VFP+VSY-1) ? SP : !SP;
                m_von = (h < HD && v < VD);
                m_rgb = pix_rgb(h, v);
                if (ft) game_step();
            end
            n++;
        end
    end

    task automatic wait_ft();
        bit seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        chk("frame_tick_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int c_pt, c_ft, c_von, c_hs, c_vs;
        rst = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);

        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        c_pt = 0; c_ft = 0; c_von = 0; c_hs = 0; c_vs = 0;
        repeat (390) begin
            @(negedge clk);
            if (p_tick)     c_pt++;
            if (frame_tick) c_ft++;
            if (video_on)   c_von++;
            if (hsync)      c_hs++;
            if (vsync)      c_vs++;
        end
        chk("frame_p_ticks", 32'(c_pt), 32'd195);
        chk("frame_ticks", 32'(c_ft), 32'd1);
        chk("frame_video_on_clks", 32'(c_von), 32'd240);
        chk("frame_hsync_clks", 32'(c_hs), 32'd26);
        chk("frame_vsync_clks", 32'(c_vs), 32'd30);

        repeat (4) wait_ft();
        @(negedge clk);
        chk("miss_before_cross", 32'(miss_cnt), 32'd0);
        wait_ft();
        @(negedge clk);
        chk("miss_after_cross", 32'(miss_cnt), 32'd1);

        repeat (37) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_pixel_x", 32'(pixel_x), 32'd0);
        chk("midrst_pixel_y", 32'(pixel_y), 32'd0);
        chk("midrst_video_on", 32'(video_on), 32'd0);
        chk("midrst_rgb", 32'(rgb), 32'd0);
        chk("midrst_miss", 32'(miss_cnt), 32'd0);

        for (int i = 0; i < 16000; i++) begin
            @(posedge clk); #1;
            en   = ($urandom_range(0, 15) != 0) && !(i >= 5000 && i < 5010);
            up   = 1'($urandom_range(0, 1));
            down = 1'($urandom_range(0, 1));
        end

        en = 1'b1; up = 1'b1; down = 1'b0;
        repeat (42000) @(posedge clk);
        #1;
        @(negedge clk);
        chk("miss_saturated", 32'(miss_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_pt2.md
Name: pong_pt2

Overview:
- Parametrised successor to the 1-bit, single-paddle pong core.
- Generates VGA raster timing for any resolution, with a configurable clock-per-pixel divider and sync polarity.
- Renders a left wall, a right player paddle and a bouncing ball on RGB_W-bit colour, and counts missed balls.
- Sits between the game-level top and the pad/DAC outputs; the SystemC/iVerilog co-simulation bench drives it.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- TICK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, sync active level (0 = active-low)
- RGB_W, 3, colour bus width
- WALL_XL / WALL_XR, 32 / 35, wall x-span (inclusive)
- PAD_XL / PAD_XR, 600 / 603, paddle x-span (inclusive)
- PAD_H, 72, paddle height
- PAD_V, 4, paddle speed (px/frame)
- BALL_SIZE, 8, ball edge length
- BALL_V, 2, ball speed per axis (px/frame)
- WALL_RGB / PAD_RGB / BALL_RGB, 3'b001 / 3'b010 / 3'b100, object colours (RGB_W bits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global run enable; 0 freezes all state
- up  in  1  paddle up request
- down  in  1  paddle down request
- p_tick  out  1  one-clk pixel strobe
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- video_on  out  1  registered visible-area flag
- rgb  out  RGB_W  pixel colour
- pixel_x  out  clog2(H_TOTAL)  current horizontal count
- pixel_y  out  clog2(V_TOTAL)  current vertical count
- frame_tick  out  1  one-clk strobe at start of vertical blank
- miss_cnt  out  4  missed-ball counter, saturating at 15

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider: tick_cnt counts 0..TICK_DIV-1 while enable=1 and holds while enable=0. p_tick = enable && tick_cnt==TICK_DIV-1. When TICK_DIV=1, p_tick=enable.
- h_cnt advances on p_tick and wraps H_TOTAL-1 -> 0. v_cnt advances on the p_tick where h_cnt wraps, and wraps V_TOTAL-1 -> 0. pixel_x/pixel_y = h_cnt/v_cnt.
- Output register, loaded on p_tick from the pre-increment h_cnt/v_cnt (one-pixel pipeline latency):
  - hsync active iff h in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1].
  - vsync active iff v in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1].
  - video_on iff h<H_DISPLAY && v<V_DISPLAY.
  - rgb = 0 outside the visible area; inside it, priority is wall > paddle > ball > background (0).
  - Wall: x in [WALL_XL, WALL_XR], all y. Paddle: x in [PAD_XL, PAD_XR], y in [pad_y, pad_y+PAD_H-1]. Ball: x in [bx, bx+BALL_SIZE-1], y in [by, by+BALL_SIZE-1].
- frame_tick = p_tick && h_cnt==H_TOTAL-1 && v_cnt==V_DISPLAY-1. Game state updates only in that cycle.
- Paddle, on frame_tick:
  - up only: pad_y <= (pad_y>PAD_V) ? pad_y-PAD_V : 0.
  - down only: pad_y <= min(pad_y+PAD_V, V_DISPLAY-PAD_H).
  - both or neither: hold.
- Ball, on frame_tick (directions first, then position from the new directions):
  - dy: set to + if by<=BALL_V; set to - if by>=V_DISPLAY-BALL_SIZE-BALL_V.
  - dx: set to + if bx<=WALL_XR+1+BALL_V.
  - Paddle hit: if dx=+, bx+BALL_SIZE in [PAD_XL, PAD_XL+BALL_V], and ball y-range overlaps paddle y-range, set dx to -.
  - Miss: if bx>=H_DISPLAY-BALL_SIZE-BALL_V, the ball respawns at centre ((H_DISPLAY-BALL_SIZE)/2, (V_DISPLAY-BALL_SIZE)/2) with dx=+, dy=+, and miss_cnt increments (saturates at 15). Miss takes priority over all other ball rules.
  - Otherwise: bx += ±BALL_V, by += ±BALL_V.
- Reset (any cycle, including mid-frame or mid-pixel): all counters 0; p_tick, frame_tick and video_on 0; hsync/vsync inactive (= !SYNC_POL); rgb 0; pad_y=(V_DISPLAY-PAD_H)/2; ball at centre with dx=+, dy=+; miss_cnt 0. Reset overrides enable.
- enable=0: every register holds and the strobes are 0. Resuming continues exactly where it stopped.

Test Plan:
- Defaults, enable=1, run 2 lines -> p_tick every 2nd clk; hsync low for exactly 96 p_ticks (192 clk), starting on the register update for h=656; line period 800 p_ticks.
- Defaults, run 1 frame -> vsync low for 2 lines starting at v=490; frame_tick once per 420000 p_ticks; video_on count 307200 per frame.
- Hold up for 60 frames from reset -> pad_y 204,200,...,0, then stays 0. Hold down -> saturates at 408. up&down together -> pad_y unchanged.
- Ball from reset (316,236), dx=+, no paddle alignment -> miss after the crossing frame; respawn (316,236); miss_cnt 1. After 20 misses -> miss_cnt 15.
- Place paddle overlapping the ball path -> dx flips to - on the contact frame; later bounces at the wall (dx +) and at the top/bottom (dy flips); the ball never overlaps the wall.
- Reduced timing (H 8/1/2/1, V 6/1/1/1, TICK_DIV=3, SYNC_POL=1): assert reset mid-frame for 1 clk -> all outputs return to reset values next clk; enable=0 for 10 clk -> h_cnt/v_cnt/rgb frozen.
